bank: RTL and testbench
=======================

// Module: bank
// PURPOSE
// - Storage array of one DRAM bank in the memory emulator: rows x columns of DEVICE_WIDTH-bit words.
// - Single clock; one access per cycle, direction chosen by rd_o_wr.
// - Sits below the bank-group/chip level, which supplies the decoded row/column address and the data path.
// - Timing (tRCD, CL, ...) is handled upstream; this block is a plain synchronous RAM with a registered read port.
// PARAMETERS
// - DEVICE_WIDTH  4   data bits per column access (x4/x8/x16 device)
// - COLWIDTH      10  column address bits; 2**COLWIDTH columns per row
// - CHWIDTH       5   row address bits; 2**CHWIDTH rows in the bank
// PORTS
// - clk      in   1             clock, all logic on rising edge
// - rst      in   1             synchronous, active-high reset
// - rd_o_wr  in   1             1 = write, 0 = read
// - dqin     in   DEVICE_WIDTH  write data
// - dqout    out  DEVICE_WIDTH  read data, registered
// - row      in   CHWIDTH       row address
// - column   in   COLWIDTH      column address
// BEHAVIOUR
// - Array: 2**(CHWIDTH+COLWIDTH) words of DEVICE_WIDTH bits.
//   - Linear index = {row, column}: row is the MSBs, column the LSBs.
//   - Every address is in range; no wrap-around or aliasing.
//   - Contents are initialised to 0 at time zero (simulation/FPGA init). rst does not clear the array.
// - Write (rd_o_wr=1, rst=0): at the rising edge, mem[{row,column}] <= dqin.
//   - Data is readable from the next cycle.
// - Read (rd_o_wr=0, rst=0): at the rising edge, dqout <= mem[{row,column}].
//   - Latency is 1 cycle: address at edge N, data on dqout after edge N.
// - During a write cycle, dqout holds its previous value (no write-through).
// - rst=1: at the edge, dqout <= 0 and the write is suppressed, whatever rd_o_wr is.
//   - Reset mid-burst aborts only the current cycle; the next cycle behaves normally.
// - No handshake; an access is accepted every cycle. Inputs must be stable around the rising edge.
// - Read and write in consecutive cycles to the same address returns the new data (read-after-write).
// - No X on dqout after the first reset or read.
// - Implementation: inferred single-port synchronous RAM with registered output, fully parameterised.
// TESTING
// - Reset: rst=1 for 2 cycles -> dqout=0. Then read row=0,col=0 -> dqout=0 (initial contents).
// - Burst write row=1, col=0..7, values 4'h4,1,9,3,D,D,5,2; then read col=0..7, one per cycle
//   -> dqout shows the same values in order, each 1 cycle after its address.
// - Boundary addresses: write 4'hA to row=31,col=1023 and 4'h5 to row=0,col=0
//   -> reads return A and 5; no aliasing between the two.
// - Write with rst=1: rd_o_wr=1, row=2, col=3, dqin=F during reset, then read (2,3) -> 0; dqout=0 during the reset cycle.
// - Read-after-write: write 4'h7 at (3,3) in cycle N, read (3,3) in cycle N+1 -> dqout=7 after edge N+1.
//   - Earlier dqout value is held during the write cycle.
// - Mid-burst reset: assert rst on the 4th read of a burst -> dqout=0 that cycle; the 5th read returns correct data.

Source files
------------

// File: rtl/bank.sv
// -----------------------------------------------------------------------------
// bank
//   Storage array of one DRAM bank in the memory emulator. The bank holds
//   2**CHWIDTH rows by 2**COLWIDTH columns of DEVICE_WIDTH-bit words.
//   The bank-group/chip level above this block handles all DRAM timing.
//   This block is a plain single-port synchronous RAM. It accepts one access
//   per cycle and drives data out through a registered read port.
//
// Ports
//   clk      in   1             rising-edge clock
//   rst      in   1             synchronous active-high reset; clears dqout
//                               and suppresses a write in the same cycle
//   rd_o_wr  in   1             1 = write, 0 = read
//   dqin     in   DEVICE_WIDTH  write data
//   dqout    out  DEVICE_WIDTH  read data, one cycle after the address
//   row      in   CHWIDTH       row address (upper part of the linear index)
//   column   in   COLWIDTH      column address (lower part of the linear index)
// -----------------------------------------------------------------------------
module bank #(
    parameter int DEVICE_WIDTH = 4,
    parameter int COLWIDTH     = 10,
    parameter int CHWIDTH      = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rd_o_wr,
    input  logic [DEVICE_WIDTH-1:0] dqin,
    output logic [DEVICE_WIDTH-1:0] dqout,
    input  logic [CHWIDTH-1:0]      row,
    input  logic [COLWIDTH-1:0]     column
);

    localparam int ADDR_W = CHWIDTH + COLWIDTH;
    localparam int DEPTH  = 2 ** ADDR_W;

    // The declaration initialiser gives a zeroed array at time zero, both in
    // simulation and as FPGA block-RAM init. rst does not touch the contents.
    logic [DEVICE_WIDTH-1:0] mem [DEPTH] = '{default: '0};

    // Row forms the MSBs and column the LSBs. The index width equals the
    // array depth exactly, so every address is distinct.
    logic [ADDR_W-1:0] addr;
    assign addr = {row, column};

    // Write port. Reset blocks the write so that an aborted cycle leaves
    // the array untouched.
    always_ff @(posedge clk) begin
        if (!rst && rd_o_wr) begin
            mem[addr] <= dqin;
        end
    end

    // Registered read port. dqout holds its value during write cycles, and
    // there is no write-through path.
    always_ff @(posedge clk) begin
        if (rst) begin
            dqout <= '0;
        end else if (!rd_o_wr) begin
            dqout <= mem[addr];
        end
    end

endmodule

// File: tb/tb_bank.sv
module tb_bank;

    localparam int DEVICE_WIDTH = 4;
    localparam int COLWIDTH     = 10;
    localparam int CHWIDTH      = 5;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    rd_o_wr;
    logic [DEVICE_WIDTH-1:0] dqin;
    logic [DEVICE_WIDTH-1:0] dqout;
    logic [CHWIDTH-1:0]      row;
    logic [COLWIDTH-1:0]     column;

    int n_vec = 0;
    int n_mis = 0;

    bank #(
        .DEVICE_WIDTH(DEVICE_WIDTH),
        .COLWIDTH    (COLWIDTH),
        .CHWIDTH     (CHWIDTH)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .rd_o_wr(rd_o_wr),
        .dqin   (dqin),
        .dqout  (dqout),
        .row    (row),
        .column (column)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [DEVICE_WIDTH-1:0] got,
                             input logic [DEVICE_WIDTH-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: dqout=%h expected=%h", tag, got, exp);
        end
    endtask

    // Apply one access across one rising edge. On return, the time is 1
    // unit after that edge, so the registered output can be sampled.
    task automatic cyc(input logic r, input logic wr, input int rw, input int cl,
                       input logic [DEVICE_WIDTH-1:0] d);
        rst     = r;
        rd_o_wr = wr;
        row     = CHWIDTH'(rw);
        column  = COLWIDTH'(cl);
        dqin    = d;
        @(posedge clk);
        #1;
    endtask

    logic [DEVICE_WIDTH-1:0] burst [8];

    initial begin
        burst = '{4'h4, 4'h1, 4'h9, 4'h3, 4'hD, 4'hD, 4'h5, 4'h2};

        // Reset for two cycles.
        cyc(1'b1, 1'b0, 0, 0, 4'h0);
        check_vec("reset_c1", dqout, 4'h0);
        cyc(1'b1, 1'b0, 0, 0, 4'h0);
        check_vec("reset_c2", dqout, 4'h0);

        // Initial contents are zero.
        cyc(1'b0, 1'b0, 0, 0, 4'h0);
        check_vec("init_rd_0_0", dqout, 4'h0);

        // Burst write to row 1, columns 0..7. dqout holds through the writes.
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b1, 1, i, burst[i]);
        end
        check_vec("hold_after_burst_wr", dqout, 4'h0);

        // Burst read back.
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b0, 1, i, 4'h0);
            check_vec($sformatf("burst_rd_col%0d", i), dqout, burst[i]);
        end

        // Boundary addresses must not alias.
        cyc(1'b0, 1'b1, 31, 1023, 4'hA);
        cyc(1'b0, 1'b1, 0, 0, 4'h5);
        cyc(1'b0, 1'b0, 31, 1023, 4'h0);
        check_vec("rd_31_1023", dqout, 4'hA);
        cyc(1'b0, 1'b0, 0, 0, 4'h0);
        check_vec("rd_0_0", dqout, 4'h5);
        cyc(1'b0, 1'b0, 31, 1022, 4'h0);
        check_vec("rd_31_1022", dqout, 4'h0);

        // A write during reset is suppressed, and dqout clears.
        cyc(1'b0, 1'b0, 1, 0, 4'h0);
        check_vec("pre_rst_rd", dqout, 4'h4);
        cyc(1'b1, 1'b1, 2, 3, 4'hF);
        check_vec("rst_wr_dqout", dqout, 4'h0);
        cyc(1'b0, 1'b0, 2, 3, 4'h0);
        check_vec("rd_2_3_after_rst_wr", dqout, 4'h0);

        // Read-after-write. The earlier value holds during the write.
        cyc(1'b0, 1'b0, 1, 2, 4'h0);
        check_vec("pre_raw_rd", dqout, 4'h9);
        cyc(1'b0, 1'b1, 3, 3, 4'h7);
        check_vec("raw_hold", dqout, 4'h9);
        cyc(1'b0, 1'b0, 3, 3, 4'h0);
        check_vec("raw_rd_3_3", dqout, 4'h7);

        // Mid-burst reset on the 4th read.
        for (int i = 0; i < 8; i++) begin
            cyc((i == 3), 1'b0, 1, i, 4'h0);
            check_vec($sformatf("midrst_rd_col%0d", i), dqout,
                      (i == 3) ? 4'h0 : burst[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
